// File: rtl/bs_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bs_pkg
// Brief    : Shared command codes, processor status codes, sequencer state
//            encoding and timer sizing for the Black-Scholes job sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package bs_pkg;

  // Processor command codes
  localparam logic [3:0] BS_CMD_NONE = 4'd0;
  localparam logic [3:0] BS_CMD_RUN  = 4'd1;
  localparam logic [3:0] BS_CMD_ACK  = 4'd2;

  // Processor status codes
  localparam logic [3:0] BS_ST_IDLE     = 4'd0;
  localparam logic [3:0] BS_ST_RUNNING  = 4'd1;
  localparam logic [3:0] BS_ST_COMPLETE = 4'd2;

  // Timeout defaults; timer is one bit wider than niter so niter+margin never wraps
  localparam int unsigned BS_TIMEOUT_MARGIN = 256;
  localparam int unsigned BS_START_TIMEOUT  = 16;
  localparam int unsigned BS_TIMER_W        = 33;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_WAIT   = 3'd3,
    S_ACK    = 3'd4,
    S_RESULT = 3'd5,
    S_FAULT  = 3'd6
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/bs_job_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : bs_job_sequencer_if
// Brief     : Job port, result port and processor command bus of the job
//             sequencer. slave = sequencer side, master = host/processor side.
// Revision  : 1.0 - initial release
// ============================================================================
interface bs_job_sequencer_if;

  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_niter;
  logic [31:0] job_k;
  logic [31:0] job_c1;
  logic [31:0] job_c2;
  logic [31:0] job_c3;

  logic [31:0] proc_niter;
  logic [31:0] proc_constK;
  logic [31:0] proc_const1;
  logic [31:0] proc_const2;
  logic [31:0] proc_const3;
  logic [3:0]  proc_cmd;
  logic [3:0]  proc_status;
  logic [31:0] proc_acc_dout;
  logic [31:0] proc_pow_acc_dout;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_acc;
  logic [31:0] res_pow_acc;
  logic        res_timeout;
  logic        busy;

  modport slave (
    input  job_valid, job_niter, job_k, job_c1, job_c2, job_c3,
    input  proc_status, proc_acc_dout, proc_pow_acc_dout,
    input  res_ready,
    output job_ready,
    output proc_niter, proc_constK, proc_const1, proc_const2, proc_const3, proc_cmd,
    output res_valid, res_acc, res_pow_acc, res_timeout, busy
  );

  modport master (
    output job_valid, job_niter, job_k, job_c1, job_c2, job_c3,
    output proc_status, proc_acc_dout, proc_pow_acc_dout,
    output res_ready,
    input  job_ready,
    input  proc_niter, proc_constK, proc_const1, proc_const2, proc_const3, proc_cmd,
    input  res_valid, res_acc, res_pow_acc, res_timeout, busy
  );

endinterface
`default_nettype wire

// File: rtl/bs_seq_timer.sv
`default_nettype none
// ============================================================================
// Module   : bs_seq_timer
// Brief    : Clearable up-counter with a compare output. expired is high in
//            the cycle whose count (including itself) reaches limit.
// Revision : 1.0 - initial release
// ============================================================================
module bs_seq_timer
  import bs_pkg::*;
#(
  parameter int unsigned WIDTH = BS_TIMER_W
) (
  input  wire              clk,
  input  wire              reset,
  input  wire              clr,
  input  wire              inc,
  input  wire  [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins over increment, otherwise hold
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q + WIDTH'(1)) >= limit;

endmodule
`default_nettype wire

// File: rtl/bs_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bs_job_sequencer
// Brief    : Accepts one job, loads it into the Black-Scholes processor,
//            issues RUN, waits for COMPLETE, ACKs and returns the results.
//            Faults on start/run timeouts with a zero result flagged timeout.
// Revision : 1.0 - initial release
// ============================================================================
module bs_job_sequencer
  import bs_pkg::*;
#(
  parameter logic [3:0]  CMD_RUN        = BS_CMD_RUN,
  parameter logic [3:0]  CMD_ACK        = BS_CMD_ACK,
  parameter logic [3:0]  ST_IDLE        = BS_ST_IDLE,
  parameter logic [3:0]  ST_RUNNING     = BS_ST_RUNNING,
  parameter logic [3:0]  ST_COMPLETE    = BS_ST_COMPLETE,
  parameter int unsigned TIMEOUT_MARGIN = BS_TIMEOUT_MARGIN,
  parameter int unsigned START_TIMEOUT  = BS_START_TIMEOUT
) (
  input wire                clk,
  input wire                reset,
  bs_job_sequencer_if.slave bus
);

  seq_state_e state_q, state_d;

  logic [3:0]  proc_cmd_q, proc_cmd_d;
  logic [31:0] proc_niter_q, proc_niter_d;
  logic [31:0] proc_constk_q, proc_constk_d;
  logic [31:0] proc_const1_q, proc_const1_d;
  logic [31:0] proc_const2_q, proc_const2_d;
  logic [31:0] proc_const3_q, proc_const3_d;
  logic [31:0] res_acc_q, res_acc_d;
  logic [31:0] res_pow_acc_q, res_pow_acc_d;
  logic        res_timeout_q, res_timeout_d;

  logic                  job_accept;
  logic                  tmr_clr;
  logic                  tmr_inc;
  logic                  tmr_expired;
  logic [BS_TIMER_W-1:0] tmr_limit;

  assign job_accept = (state_q == S_IDLE) && bus.job_valid;

  bs_seq_timer #(
    .WIDTH (BS_TIMER_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: success conditions take priority over the timeout in each waiting state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.job_valid) state_d = S_LOAD;
      S_LOAD: begin
        if (bus.proc_status == ST_IDLE) state_d = S_RUN;
        else if (tmr_expired)           state_d = S_FAULT;
      end
      S_RUN: begin
        if (bus.proc_status == ST_RUNNING) state_d = S_WAIT;
        else if (tmr_expired)              state_d = S_FAULT;
      end
      S_WAIT: begin
        if (bus.proc_status == ST_COMPLETE) state_d = S_ACK;
        else if (tmr_expired)               state_d = S_FAULT;
      end
      S_ACK:    if (bus.proc_status == ST_IDLE) state_d = S_RESULT;
      S_RESULT: if (bus.res_ready) state_d = S_IDLE;
      S_FAULT:  state_d = S_RESULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs: the command follows the state being entered so it is registered alongside it
  always_comb begin
    proc_cmd_d = BS_CMD_NONE;
    case (state_d)
      S_RUN:   proc_cmd_d = CMD_RUN;
      S_ACK:   proc_cmd_d = CMD_ACK;
      // A processor left in COMPLETE by an earlier fault or reset is ACKed before RUN
      S_LOAD:  proc_cmd_d = (bus.proc_status == ST_COMPLETE) ? CMD_ACK : BS_CMD_NONE;
      default: proc_cmd_d = BS_CMD_NONE;
    endcase

    proc_niter_d  = proc_niter_q;
    proc_constk_d = proc_constk_q;
    proc_const1_d = proc_const1_q;
    proc_const2_d = proc_const2_q;
    proc_const3_d = proc_const3_q;
    if (job_accept) begin
      proc_niter_d  = bus.job_niter;
      proc_constk_d = bus.job_k;
      proc_const1_d = bus.job_c1;
      proc_const2_d = bus.job_c2;
      proc_const3_d = bus.job_c3;
    end

    res_acc_d     = res_acc_q;
    res_pow_acc_d = res_pow_acc_q;
    res_timeout_d = res_timeout_q;
    if ((state_q == S_WAIT) && (bus.proc_status == ST_COMPLETE)) begin
      res_acc_d     = bus.proc_acc_dout;
      res_pow_acc_d = bus.proc_pow_acc_dout;
      res_timeout_d = 1'b0;
    end else if (state_q == S_FAULT) begin
      res_acc_d     = '0;
      res_pow_acc_d = '0;
      res_timeout_d = 1'b1;
    end

    tmr_clr   = (state_d != state_q);
    tmr_inc   = (state_q inside {S_LOAD, S_RUN, S_WAIT});
    tmr_limit = (state_q == S_WAIT) ? ({1'b0, proc_niter_q} + BS_TIMER_W'(TIMEOUT_MARGIN))
                                    : BS_TIMER_W'(START_TIMEOUT);
  end

  // Registered command, job constants and captured results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proc_cmd_q    <= BS_CMD_NONE;
      proc_niter_q  <= '0;
      proc_constk_q <= '0;
      proc_const1_q <= '0;
      proc_const2_q <= '0;
      proc_const3_q <= '0;
      res_acc_q     <= '0;
      res_pow_acc_q <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      proc_cmd_q    <= proc_cmd_d;
      proc_niter_q  <= proc_niter_d;
      proc_constk_q <= proc_constk_d;
      proc_const1_q <= proc_const1_d;
      proc_const2_q <= proc_const2_d;
      proc_const3_q <= proc_const3_d;
      res_acc_q     <= res_acc_d;
      res_pow_acc_q <= res_pow_acc_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign bus.job_ready   = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.res_valid   = (state_q == S_RESULT);
  assign bus.proc_cmd    = proc_cmd_q;
  assign bus.proc_niter  = proc_niter_q;
  assign bus.proc_constK = proc_constk_q;
  assign bus.proc_const1 = proc_const1_q;
  assign bus.proc_const2 = proc_const2_q;
  assign bus.proc_const3 = proc_const3_q;
  assign bus.res_acc     = res_acc_q;
  assign bus.res_pow_acc = res_pow_acc_q;
  assign bus.res_timeout = res_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_bs_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bs_job_sequencer
// Brief    : Self-checking bench for bs_job_sequencer with a behavioural
//            processor model and randomized jobs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bs_job_sequencer;
  import bs_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bs_job_sequencer_if bus ();

  bs_job_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural processor: IDLE -RUN-> RUNNING for p_lat cycles -> COMPLETE -ACK-> IDLE
  logic [3:0]  p_state = BS_ST_IDLE;
  int          p_cnt = 0;
  int          p_lat;
  logic        p_hang;
  logic        p_rst;
  logic [31:0] p_acc;
  logic [31:0] p_pow;

  assign bus.proc_status       = p_state;
  assign bus.proc_acc_dout     = p_acc;
  assign bus.proc_pow_acc_dout = p_pow;

  // Processor reacts to the command it sees at each rising edge
  always @(posedge clk) begin
    if (p_rst) begin
      p_state <= BS_ST_IDLE;
      p_cnt   <= 0;
    end else begin
      case (p_state)
        BS_ST_IDLE: if (bus.proc_cmd == BS_CMD_RUN) begin
          p_state <= BS_ST_RUNNING;
          p_cnt   <= 0;
        end
        BS_ST_RUNNING: if (!p_hang) begin
          if (p_cnt + 1 >= p_lat) p_state <= BS_ST_COMPLETE;
          p_cnt <= p_cnt + 1;
        end
        BS_ST_COMPLETE: if (bus.proc_cmd == BS_CMD_ACK) p_state <= BS_ST_IDLE;
        default: p_state <= BS_ST_IDLE;
      endcase
    end
  end

  typedef struct packed {
    logic [31:0] niter;
    logic [31:0] k;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [31:0] c3;
  } job_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-job observations of the command/status traffic
  int         cyc = 0;
  int         first_run, first_ack, first_runst, first_cmpl, run_trains, ack_trains;
  logic [3:0] prev_cmd;

  task automatic mon_clear();
    first_run   = -1;
    first_ack   = -1;
    first_runst = -1;
    first_cmpl  = -1;
    run_trains  = 0;
    ack_trains  = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.proc_cmd == BS_CMD_RUN && prev_cmd != BS_CMD_RUN) begin
      run_trains++;
      if (first_run < 0) first_run = cyc;
    end
    if (bus.proc_cmd == BS_CMD_ACK && prev_cmd != BS_CMD_ACK) begin
      ack_trains++;
      if (first_ack < 0) first_ack = cyc;
    end
    if (bus.proc_status == BS_ST_RUNNING && first_runst < 0) first_runst = cyc;
    if (bus.proc_status == BS_ST_COMPLETE && first_runst >= 0 && first_cmpl < 0) first_cmpl = cyc;
    prev_cmd = bus.proc_cmd;
  endtask

  function automatic job_t rand_job(input logic [31:0] niter);
    job_t j;
    j.niter = niter;
    j.k     = $urandom;
    j.c1    = $urandom;
    j.c2    = $urandom;
    j.c3    = $urandom;
    return j;
  endfunction

  task automatic drive_job(input job_t j);
    bus.job_niter = j.niter;
    bus.job_k     = j.k;
    bus.job_c1    = j.c1;
    bus.job_c2    = j.c2;
    bus.job_c3    = j.c3;
    bus.job_valid = 1'b1;
  endtask

  // Returns the cycle in which the job transferred; leaves time one cycle later
  task automatic wait_accept(output int acc_cyc);
    int n = 0;
    while (!(bus.job_ready && bus.job_valid) && n < 400) begin
      tick();
      n++;
    end
    chk("accept_seen", bus.job_ready, 1'b1);
    acc_cyc = cyc;
    mon_clear();
    tick();
  endtask

  task automatic wait_result(input int hold, input logic [31:0] ea, input logic [31:0] ep,
                             input logic et, input string tag, output int rv_cyc, output int hs_cyc);
    int n = 0;
    while (!bus.res_valid && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, "_res_valid"}, bus.res_valid, 1'b1);
    rv_cyc = cyc;
    chk({tag, "_acc_pow"}, {bus.res_acc, bus.res_pow_acc}, {ea, ep});
    chk({tag, "_timeout"}, bus.res_timeout, et);
    chk({tag, "_busy_ready"}, {bus.busy, bus.job_ready}, 2'b10);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid_ready"}, {bus.res_valid, bus.job_ready}, 2'b10);
      chk({tag, "_hold_data"}, {bus.res_acc, bus.res_pow_acc}, {ea, ep});
    end
    bus.res_ready = 1'b1;
    hs_cyc = cyc;
    tick();
    bus.res_ready = 1'b0;
    chk({tag, "_after_hs"}, {bus.res_valid, bus.job_ready}, 2'b01);
  endtask

  int   a, rv, hs, n;
  job_t ja, jb;
  logic [31:0] ea, ep;

  // Standard job against a compliant processor
  task automatic run_std(input job_t j, input int lat, input logic [31:0] acc, input logic [31:0] pow,
                         input int hold, input logic leftover, input string tag);
    int acc_c, rv_c, hs_c;
    p_lat  = lat;
    p_acc  = acc;
    p_pow  = pow;
    p_hang = 1'b0;
    drive_job(j);
    wait_accept(acc_c);
    bus.job_valid = 1'b0;
    wait_result(hold, acc, pow, 1'b0, tag, rv_c, hs_c);
    chk({tag, "_valid_n3"}, 64'(rv_c - first_cmpl), 64'd3);
    chk({tag, "_run_trains"}, 64'(run_trains), 64'd1);
    if (leftover) begin
      chk({tag, "_ack_trains"}, 64'(ack_trains), 64'd2);
      chk({tag, "_ack_before_run"}, (first_ack >= 0) && (first_ack < first_run), 1'b1);
    end else begin
      chk({tag, "_ack_trains"}, 64'(ack_trains), 64'd1);
      chk({tag, "_run_latency"}, 64'(first_run - acc_c), 64'd2);
    end
    chk({tag, "_niter_k"}, {bus.proc_niter, bus.proc_constK}, {j.niter, j.k});
    chk({tag, "_c1_c2"}, {bus.proc_const1, bus.proc_const2}, {j.c1, j.c2});
    chk({tag, "_c3"}, bus.proc_const3, j.c3);
  endtask

  initial begin
    reset = 1'b1;
    bus.job_valid = 1'b0;
    bus.job_niter = '0;
    bus.job_k     = '0;
    bus.job_c1    = '0;
    bus.job_c2    = '0;
    bus.job_c3    = '0;
    bus.res_ready = 1'b0;
    p_rst  = 1'b1;
    p_hang = 1'b0;
    p_lat  = 1;
    p_acc  = '0;
    p_pow  = '0;
    prev_cmd = BS_CMD_NONE;
    mon_clear();
    repeat (3) tick();
    chk("rst_ready_busy_valid", {bus.job_ready, bus.busy, bus.res_valid}, 3'b100);
    chk("rst_cmd", bus.proc_cmd, BS_CMD_NONE);
    chk("rst_niter_k", {bus.proc_niter, bus.proc_constK}, 64'd0);
    chk("rst_res", {bus.res_acc, bus.res_pow_acc}, 64'd0);
    chk("rst_timeout", bus.res_timeout, 1'b0);
    reset = 1'b0;
    p_rst = 1'b0;
    tick();

    // Reference job
    ja = rand_job(32'd4);
    ja.k = 32'h41200000;
    run_std(ja, 62, 32'h3F800000, 32'h40000000, 0, 1'b0, "ref");

    // Result held back by res_ready
    run_std(rand_job(32'($urandom_range(1, 20))), $urandom_range(1, 30), $urandom, $urandom, 10, 1'b0, "hold");

    // Processor never completes: fault after niter+margin WAIT cycles
    ja = rand_job(32'd8);
    p_hang = 1'b1;
    drive_job(ja);
    wait_accept(a);
    bus.job_valid = 1'b0;
    wait_result(0, 32'd0, 32'd0, 1'b1, "hang", rv, hs);
    chk("hang_latency", 64'(rv - first_runst), 64'(8 + 256 + 2));
    chk("hang_trains", {32'(run_trains), 32'(ack_trains)}, {32'd1, 32'd0});
    p_hang = 1'b0;
    p_rst  = 1'b1;
    tick();
    p_rst = 1'b0;
    tick();

    // Reset in the middle of WAIT; processor is left to reach COMPLETE on its own
    p_lat = 80;
    ja = rand_job(32'd10);
    drive_job(ja);
    wait_accept(a);
    bus.job_valid = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    #1;
    chk("midrst_ready_busy_valid", {bus.job_ready, bus.busy, bus.res_valid}, 3'b100);
    chk("midrst_cmd", bus.proc_cmd, BS_CMD_NONE);
    chk("midrst_niter_k", {bus.proc_niter, bus.proc_constK}, 64'd0);
    chk("midrst_res", {bus.res_acc, bus.res_pow_acc, 31'd0, bus.res_timeout}, 96'd0);
    tick();
    tick();
    reset = 1'b0;
    n = 0;
    while (p_state != BS_ST_COMPLETE && n < 200) begin
      tick();
      n++;
    end
    run_std(rand_job(32'($urandom_range(0, 20))), 5, $urandom, $urandom, 1, 1'b1, "leftover");

    // Back-to-back jobs with job_valid held high
    ja = rand_job(32'($urandom_range(1, 30)));
    jb = rand_job(32'($urandom_range(1, 30)));
    p_lat = $urandom_range(1, 20);
    p_acc = $urandom;
    p_pow = $urandom;
    ea = p_acc;
    ep = p_pow;
    drive_job(ja);
    wait_accept(a);
    drive_job(jb);
    chk("b2b_constA_early", {bus.proc_niter, bus.proc_constK}, {ja.niter, ja.k});
    wait_result(2, ea, ep, 1'b0, "b2bA", rv, hs);
    chk("b2b_constA_hold", {bus.proc_const1, bus.proc_const2}, {ja.c1, ja.c2});
    p_acc = $urandom;
    p_pow = $urandom;
    ea = p_acc;
    ep = p_pow;
    wait_accept(a);
    chk("b2b_accept_gap", 64'(a - hs), 64'd1);
    bus.job_valid = 1'b0;
    chk("b2b_constB", {bus.proc_niter, bus.proc_const3}, {jb.niter, jb.c3});
    wait_result(0, ea, ep, 1'b0, "b2bB", rv, hs);

    // Randomized jobs, including niter = 0
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_std(rand_job((i == 0) ? 32'd0 : 32'($urandom_range(1, 50))), $urandom_range(1, 30),
              $urandom, $urandom, $urandom_range(0, 3), 1'b0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
